// File: rtl/sound_sequencer.sv
// Sound-effect sequencer: arbitrates eat/start/die requests and steps through a
// fixed note table, driving the tone oscillator note by note on tick strobes.
module sound_sequencer #(
    parameter int NOTE_TICKS = 4,
    parameter int GAP_TICKS  = 2,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       tick,
    input  logic       req_eat,
    input  logic       req_start,
    input  logic       req_die,
    input  logic       mute,
    output logic [8:0] freq,
    output logic       osc_on,
    output logic       play_sound,
    output logic       busy,
    output logic [1:0] cur_snd,
    output logic       done
);

    typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;

    localparam logic [8:0]       F_IDLE    = 9'd262;
    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [1:0]       SND_EAT   = 2'd1;
    localparam logic [1:0]       SND_START = 2'd2;
    localparam logic [1:0]       SND_DIE   = 2'd3;

    // Unused table slots fall back to 262 so freq can never be 0.
    function automatic logic [8:0] note_freq(input logic [1:0] snd, input logic [1:0] idx);
        case ({snd, idx})
            4'b01_00: note_freq = 9'd262;
            4'b01_01: note_freq = 9'd392;
            4'b10_00: note_freq = 9'd262;
            4'b10_01: note_freq = 9'd330;
            4'b10_10: note_freq = 9'd392;
            4'b11_00: note_freq = 9'd392;
            4'b11_01: note_freq = 9'd330;
            4'b11_10: note_freq = 9'd262;
            4'b11_11: note_freq = 9'd196;
            default:  note_freq = 9'd262;
        endcase
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] snd);
        case (snd)
            SND_EAT:   last_idx = 2'd1;
            SND_START: last_idx = 2'd2;
            SND_DIE:   last_idx = 2'd3;
            default:   last_idx = 2'd0;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       snd_q, snd_d;
    logic [8:0]       freq_q, freq_d;
    logic             osc_on_q, osc_on_d;
    logic             play_q, play_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             end_note;
    logic             preempt;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        snd_d    = snd_q;
        done_d   = 1'b0;
        end_note = 1'b0;
        preempt  = req_die && (snd_q != SND_DIE);

        case (state_q)
            S_IDLE: begin
                if (req_die || req_start || req_eat) begin
                    state_d = S_NOTE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    snd_d   = req_die ? SND_DIE : (req_start ? SND_START : SND_EAT);
                end
            end
            S_NOTE: begin
                if (preempt) begin
                    state_d = S_NOTE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    snd_d   = SND_DIE;
                end else if (tick) begin
                    if (cnt_q == NOTE_LAST) begin
                        cnt_d = '0;
                        if (GAP_TICKS == 0) begin
                            end_note = 1'b1;
                        end else begin
                            state_d = S_GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (preempt) begin
                    state_d = S_NOTE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    snd_d   = SND_DIE;
                end else if (tick) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d    = '0;
                        end_note = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // End of a note's gap: either advance to the next note or finish the effect.
        if (end_note) begin
            if (idx_q == last_idx(snd_q)) begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
                snd_d   = 2'd0;
                done_d  = 1'b1;
            end else begin
                state_d = S_NOTE;
                idx_d   = idx_q + 1'b1;
            end
        end

        // Outputs are registered, so they are derived from the next state.
        case (state_d)
            S_IDLE:  freq_d = F_IDLE;
            S_NOTE:  freq_d = note_freq(snd_d, idx_d);
            default: freq_d = freq_q;
        endcase
        osc_on_d = (state_d == S_NOTE);
        play_d   = (state_d == S_NOTE) && !mute;
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= '0;
            snd_q    <= 2'd0;
            freq_q   <= F_IDLE;
            osc_on_q <= 1'b0;
            play_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            snd_q    <= snd_d;
            freq_q   <= freq_d;
            osc_on_q <= osc_on_d;
            play_q   <= play_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign freq       = freq_q;
    assign osc_on     = osc_on_q;
    assign play_sound = play_q;
    assign busy       = busy_q;
    assign cur_snd    = snd_q;
    assign done       = done_q;

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
Plays the game's sound effects by driving the tone oscillator. Accepts one-cycle event requests from game logic: eat, start and die. Arbitrates between requests by fixed priority. Steps through a fixed note table for the chosen effect, presenting freq, oscillator enable and play-sound gating note by note, timed by an external tick strobe.

Parameters:
NOTE_TICKS, 4, tick strobes per sounding note (must be >= 1)
GAP_TICKS, 2, silent tick strobes after each note (0 = no gap state)
CNT_W, 8, width of tick counter (must hold max(NOTE_TICKS, GAP_TICKS))

Ports:
clk  input  1  system clock
nRst  input  1  asynchronous active-low reset
tick  input  1  one-cycle timing strobe (e.g. 100 Hz enable)
req_eat  input  1  request eat effect, priority lowest
req_start  input  1  request start effect, priority middle
req_die  input  1  request die effect, priority highest, may preempt
mute  input  1  suppresses play_sound; sequencing continues
freq  output  9  tone frequency to oscillator, never 0
osc_on  output  1  oscillator mode: 1 = ON, 0 = OFF (OFF clears oscillator count)
play_sound  output  1  oscillator count enable
busy  output  1  1 while an effect is in progress
cur_snd  output  2  active effect: 0 none, 1 eat, 2 start, 3 die
done  output  1  one-cycle pulse when an effect completes normally

Behaviour:
- Reset is asynchronous, active-low, on nRst. All outputs are registered.
- Reset values: freq=262, osc_on=0, play_sound=0, busy=0, cur_snd=0, done=0. State is IDLE, note index 0, tick count 0.
- Note tables, 9-bit unsigned Hz:
  - eat: 262, 392
  - start: 262, 330, 392
  - die: 392, 330, 262, 196
- FSM states: IDLE, NOTE, GAP.
- IDLE:
  - Requests are sampled on each clk edge.
  - Priority: die > start > eat. Lower-priority requests asserted in the same cycle are dropped; there is no queue.
  - On a winning request, the next cycle enters NOTE with index 0, count 0. freq is table[0], osc_on=1, busy=1, cur_snd set.
  - Latency from request cycle to outputs valid: 1 clk.
- NOTE:
  - osc_on=1; play_sound=~mute.
  - Count increments only on tick.
  - On a tick with count==NOTE_TICKS-1: count clears, then go to GAP. If GAP_TICKS==0, instead apply the end-of-gap rule directly.
  - A note therefore lasts exactly NOTE_TICKS ticks.
- GAP:
  - osc_on=0, play_sound=0; freq holds the last note value.
  - On a tick with count==GAP_TICKS-1:
    - If this is the last note: go to IDLE, busy=0, cur_snd=0, freq=262, done=1 for one cycle.
    - Otherwise: index+1, go to NOTE with freq=table[index+1].
- Preemption:
  - req_die while busy with eat or start restarts at die note 0 on the next cycle: count cleared, NOTE state, cur_snd=3, no done pulse.
  - req_die while die is playing is ignored.
  - req_eat and req_start while busy are ignored.
- tick coincident with a request in IDLE is not counted; counting begins the cycle after entry to NOTE.
- mute toggling mid-effect affects only play_sound, from the next cycle. Timing is unaffected.
- freq is never 0, which prevents divide-by-zero in the oscillator.
- done and a new request in the same cycle: the new request is accepted from IDLE only, i.e. on the cycle after done.
- nRst asserted mid-effect: immediate return to reset values; no done pulse.

Test Plan:
- Reset with all requests asserted -> freq=262, osc_on=0, busy=0, done=0. After nRst release, with requests held low, the block stays idle.
- req_eat pulse, then ticks every 10 clk:
  - next clk: freq=262, osc_on=1, cur_snd=1.
  - after 4 ticks: osc_on=0 for 2 ticks.
  - then freq=392 for 4 ticks, 2 gap ticks, then one done pulse, busy=0.
  - total 12 ticks.
- req_eat, req_start and req_die in the same cycle -> cur_snd=3, freq sequence 392, 330, 262, 196. Eat and start never play.
- req_start, then req_die during the 2nd note -> next clk freq=392, cur_snd=3, count restarts, no done pulse for start. Die completes with done after 24 ticks.
- mute=1 across an eat effect -> play_sound=0 throughout. osc_on, freq and done timing are identical to the unmuted run.
- nRst pulsed during the die 3rd note -> outputs return to reset values immediately. A later req_eat plays normally from note 0.
